screen_loader: RTL

//  Write-side counterpart of the screen image ROM readers: fills a 128x96 12-bit RGB image BRAM
//  (port A, write-only) from a byte stream (UART rx / host I/O) so win/title screens can be

---
 rtl/screen_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/screen_loader.sv
// screen_loader: fills a 128x96 12-bit RGB image BRAM from a byte stream.
// Two bytes per pixel ({R,G} then {x,B}), written at {row,col} sparse addresses.
// Optional feature macro: LOADER_CHECKSUM_EN enables the frame pixel-sum accumulator;
// without it pChecksum is tied to zero.
module screen_loader #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 96,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 7
) (
  input  logic                     pClk,
  input  logic                     pReset_n,
  input  logic                     pStart,
  input  logic                     pAbort,
  input  logic [7:0]               pByte,
  input  logic                     pValid,
  output logic                     pReady,
  output logic                     pWe,
  output logic [ROW_W+COL_W-1:0]   pAddr,
  output logic [11:0]              pDin,
  output logic                     pBusy,
  output logic                     pDone,
  output logic [15:0]              pChecksum
);

  typedef enum logic [2:0] {IDLE, HI, LO, WR, DONE} state_t;

  state_t             stateQ, stateD;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [7:0]         hiByte;
  logic               lastCol;
  logic               lastPix;
  logic               startOk;
  logic               hsHi;
  logic               hsLo;

  assign lastCol = (col == COL_W'(WIDTH - 1));
  assign lastPix = lastCol && (row == ROW_W'(HEIGHT - 1));
  assign startOk = (stateQ == IDLE) && pStart && !pAbort;
  assign hsHi    = (stateQ == HI) && pValid && pReady;
  assign hsLo    = (stateQ == LO) && pValid && pReady;

  // State register
  always_ff @(posedge pClk) begin
    if (!pReset_n) stateQ <= IDLE;
    else           stateQ <= stateD;
  end

  // Next-state and handshake/status outputs; abort wins from every non-idle state
  always_comb begin
    stateD = stateQ;
    pReady = 1'b0;
    pBusy  = 1'b0;
    pDone  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (pStart && !pAbort) stateD = HI;
      end
      HI: begin
        pBusy  = 1'b1;
        pReady = !pAbort;
        if (pAbort)      stateD = IDLE;
        else if (pValid) stateD = LO;
      end
      LO: begin
        pBusy  = 1'b1;
        pReady = !pAbort;
        if (pAbort)      stateD = IDLE;
        else if (pValid) stateD = WR;
      end
      WR: begin
        pBusy = 1'b1;
        if (pAbort)       stateD = IDLE;
        else if (lastPix) stateD = DONE;
        else              stateD = HI;
      end
      DONE: begin
        pDone  = 1'b1;
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Column/row walk; the final pixel wraps col but leaves row at HEIGHT-1
  always_ff @(posedge pClk) begin
    if (!pReset_n) begin
      col <= '0;
      row <= '0;
    end else if (startOk) begin
      col <= '0;
      row <= '0;
    end else if (stateQ == WR && !pAbort) begin
      if (lastCol) begin
        col <= '0;
        if (!lastPix) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // First byte of a pixel carries {R,G}
  always_ff @(posedge pClk) begin
    if (hsHi) hiByte <= pByte;
  end

  // BRAM write port: address/data hold their last values between pixels
  always_ff @(posedge pClk) begin
    if (!pReset_n) begin
      pWe   <= 1'b0;
      pAddr <= '0;
      pDin  <= '0;
    end else begin
      pWe <= hsLo;
      if (hsLo) begin
        pAddr <= {row, col};
        pDin  <= {hiByte, pByte[3:0]};
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sumQ;

  // Running sum of every written pixel, wraps modulo 2**16
  always_ff @(posedge pClk) begin
    if (!pReset_n)    sumQ <= '0;
    else if (startOk) sumQ <= '0;
    else if (pWe)     sumQ <= sumQ + {4'h0, pDin};
  end

  assign pChecksum = sumQ;
`else
  assign pChecksum = 16'd0;
`endif

endmodule
